lpc_record_serializer: RTL and testbench

- Downstream stage of the LPC clock-domain buffer: consumes the single-cycle strobe plus captured record (address/data/type) in the system clock domain.
- Queues records in a small FIFO and serializes each into a framed byte stream (header, payload MSB-first, XOR checksum) for the UART transmitter.
- Absorbs LPC bursts; counts records lost to overflow.

---
 rtl/lpc_sniffer_pkg.sv | 27 ++
 rtl/lpc_record_serializer_if.sv | 21 ++
 rtl/lpc_record_fifo.sv | 62 ++++++
 rtl/lpc_record_serializer.sv | 131 +++++++++++++
 tb/tb_lpc_record_serializer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_sniffer_pkg.sv
// Shared types and helpers for the LPC record serializer slice: framing FSM
// states, default frame header and byte/checksum helpers.
package lpc_sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CHK  = 2'd3
    } ser_state_e;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    function automatic int byte_count(input int dw);
        return dw / 8;
    endfunction

    // Index counter width; a one-byte record still needs a 1-bit index.
    function automatic int idx_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    function automatic logic [7:0] chk_fold(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/lpc_record_serializer_if.sv
// Record-in / byte-out handshake bundle between the LPC buffer, the
// serializer and the UART transmitter.
interface lpc_record_serializer_if #(
    parameter int DW = 48
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_byte, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_byte, out_valid
    );
endinterface

// File: rtl/lpc_record_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted only when a
// pop happens on the same edge.
module lpc_record_fifo #(
    parameter int DW    = 48,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == LW'(0));
    assign do_pop_s   = pop_i && !empty_o;
    assign do_push_s  = push_i && (!full_o || do_pop_s);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/lpc_record_serializer.sv
// Queues LPC records and frames each as HEADER, payload bytes MSB-first and
// an XOR checksum of the payload, handed byte-by-byte to the UART.
module lpc_record_serializer
    import lpc_sniffer_pkg::*;
#(
    parameter int         DW     = 48,
    parameter int         DEPTH  = 8,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic                    clock,
    input  logic                    reset,
    lpc_record_serializer_if.slave  bus,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              drop_count,
    output logic                    overflow
);
    localparam int NB = byte_count(DW);
    localparam int IW = idx_width(NB);

    ser_state_e    state_q;
    logic [DW-1:0] sreg_q;
    logic [7:0]    chk_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    out_byte_q;
    logic          out_valid_q;
    logic [7:0]    drop_q;
    logic          ovf_q;

    logic [DW-1:0] head_s;
    logic [DW-1:0] sreg_shift_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;
    logic          xfer_s;
    logic          drop_s;

    assign pop_s        = (state_q == IDLE) && !fifo_empty_s;
    assign xfer_s       = out_valid_q && bus.out_ready;
    assign drop_s       = bus.in_valid && fifo_full_s && !pop_s;
    assign sreg_shift_s = sreg_q << 8;

    lpc_record_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (bus.in_valid),
        .push_data_i (bus.in_data),
        .pop_i       (pop_s),
        .pop_data_o  (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .level_o     (fifo_level)
    );

    // Framing FSM: out_byte only changes on a transfer, so it is stable under stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            sreg_q      <= {DW{1'b0}};
            chk_q       <= 8'h00;
            idx_q       <= IW'(0);
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        sreg_q      <= head_s;
                        chk_q       <= 8'h00;
                        out_byte_q  <= HEADER;
                        out_valid_q <= 1'b1;
                        state_q     <= HDR;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (xfer_s) begin
                        out_byte_q <= sreg_q[DW-1 -: 8];
                        idx_q      <= IW'(0);
                        state_q    <= PAY;
                    end
                end
                PAY: begin
                    if (xfer_s) begin
                        chk_q  <= chk_fold(chk_q, out_byte_q);
                        sreg_q <= sreg_shift_s;
                        if (idx_q == IW'(NB - 1)) begin
                            out_byte_q <= chk_fold(chk_q, out_byte_q);
                            state_q    <= CHK;
                        end else begin
                            out_byte_q <= sreg_shift_s[DW-1 -: 8];
                            idx_q      <= idx_q + IW'(1);
                        end
                    end
                end
                CHK: begin
                    if (xfer_s) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            drop_q <= 8'h00;
            ovf_q  <= 1'b0;
        end else if (drop_s) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'h01;
            end
        end
    end

    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign drop_count    = drop_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Scoreboard bench: a queue-level reference model predicts frames, occupancy
// and drops; a negedge monitor compares every DUT byte and status output.
module tb_lpc_record_serializer;
    localparam int         DW       = 48;
    localparam int         DEPTH    = 8;
    localparam int         NB       = DW / 8;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] fifo_level;
    logic [7:0] drop_count;
    logic       overflow;

    lpc_record_serializer_if #(.DW(DW)) bus ();

    lpc_record_serializer #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .HEADER (HDR_BYTE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [DW-1:0] mq [$];
    logic [7:0]    expq [$];
    int            m_busy = 0;
    int            m_drop = 0;
    bit            m_ovf  = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock edge of the reference: frames are popped only when no frame
    // is in flight, and a frame occupies NB+2 accepted bytes.
    task automatic model_step();
        logic [DW-1:0] rec;
        logic [7:0]    c;
        logic [7:0]    b;
        bit            pop;
        if (!reset) begin
            mq.delete();
            expq.delete();
            m_busy = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            pop = (m_busy == 0) && (mq.size() > 0);
            if (pop) begin
                rec = mq.pop_front();
                expq.push_back(HDR_BYTE);
                c = 8'h00;
                for (int k = 0; k < NB; k++) begin
                    b = 8'(rec >> (8 * (NB - 1 - k)));
                    c = c ^ b;
                    expq.push_back(b);
                end
                expq.push_back(c);
                m_busy = NB + 2;
            end else if (m_busy > 0 && bus.out_ready) begin
                m_busy--;
            end
            if (bus.in_valid) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(bus.in_data);
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic rdy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);
        reset = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_rec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_busy > 0 || mq.size() > 0) && guard < 2000) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        check("drain_bound", 64'(guard < 2000), 64'd1);
        cycle(1'b0, '0, 1'b1);
    endtask

    // Monitor: scoreboard pop on every transfer plus status comparison.
    always @(negedge clock) begin
        if (mon_en) begin
            check("out_valid", bus.out_valid, 64'(m_busy > 0));
            check("fifo_level", fifo_level, mq.size());
            check("drop_count", drop_count, m_drop);
            check("overflow", overflow, m_ovf);
            if (prev_stall && bus.out_valid) begin
                check("stall_stable", bus.out_byte, prev_byte);
            end
            if (bus.out_valid && bus.out_ready && reset) begin
                if (expq.size() == 0) begin
                    check("unexpected_byte", bus.out_byte, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("out_byte", bus.out_byte, expq.pop_front());
                end
            end
            prev_stall <= bus.out_valid && !bus.out_ready && reset;
            prev_byte  <= bus.out_byte;
        end
    end

    initial begin
        logic [7:0] saved_drop;
        int         g;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);
        do_reset();
        mon_en = 1'b1;
        check("rst_valid", bus.out_valid, 64'd0);
        check("rst_byte", bus.out_byte, 64'h00);
        check("rst_level", fifo_level, 64'd0);
        check("rst_drop", drop_count, 64'd0);
        check("rst_ovf", overflow, 64'd0);

        // Single record, UART always ready; header appears one edge after the push.
        cycle(1'b1, 48'h0A40_1234_5601, 1'b1);
        check("push_edge_valid", bus.out_valid, 64'd0);
        cycle(1'b0, '0, 1'b1);
        check("hdr_latency", bus.out_valid, 64'd1);
        check("hdr_byte", bus.out_byte, 64'hA5);
        drain();

        // Same record with out_ready toggling every cycle.
        cycle(1'b1, 48'h0A40_1234_5601, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, '0, 1'(i % 2));
        drain();

        // Stall one frame in flight, then burst 10 strobes into the empty FIFO.
        cycle(1'b1, rand_rec(), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_rec(), 1'b0);
        check("burst_level", fifo_level, 64'd8);
        check("burst_drop", drop_count, 64'd2);
        check("burst_ovf", overflow, 64'd1);
        drain();
        check("ovf_sticky", overflow, 64'd1);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, rand_rec(), 1'b0);
        check("sat_drop", drop_count, 64'd255);
        check("sat_ovf", overflow, 64'd1);

        // Full FIFO with a strobe on the same edge as the IDLE pop.
        do_reset();
        cycle(1'b1, rand_rec(), 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_rec(), 1'b0);
        check("fill_level", fifo_level, 64'd8);
        g = 0;
        while (m_busy > 0 && g < 100) begin
            cycle(1'b0, '0, 1'b1);
            g++;
        end
        saved_drop = drop_count;
        cycle(1'b1, rand_rec(), 1'b1);
        check("coinc_level", fifo_level, 64'd8);
        check("coinc_drop", drop_count, 64'(saved_drop));
        check("coinc_valid", bus.out_valid, 64'd1);
        drain();

        // Reset after the third payload byte of a frame.
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, rand_rec(), 1'b0);
        g = 0;
        while (m_busy != 4 && g < 50) begin
            cycle(1'b0, '0, 1'b1);
            g++;
        end
        check("midpay_reached", 64'(m_busy), 64'd4);
        do_reset();
        check("midpay_valid", bus.out_valid, 64'd0);
        check("midpay_level", fifo_level, 64'd0);
        check("midpay_drop", drop_count, 64'd0);
        cycle(1'b1, rand_rec(), 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("fresh_hdr", bus.out_byte, 64'hA5);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 4), rand_rec(), 1'($urandom_range(0, 9) < 7));
        end
        drain();
        check("scoreboard_empty", expq.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
